// File: rtl/l2_pf_cov_pkg.sv
// rtl/l2_pf_cov_pkg.sv - shared types for the prefetch coverage rolling controller
package l2_pf_cov_pkg;

  localparam int CNT_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } pf_cov_state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] yAxisPt;
    logic [CNT_W_DEF-1:0] xAxisPt;
    logic [CNT_W_DEF-1:0] stamp;
  } pf_cov_rec_t;

endpackage

// File: rtl/l2_pf_cov_rolling_ctrl.sv
// rtl/l2_pf_cov_rolling_ctrl.sv - windowed useful-prefetch coverage sampler feeding the rolling table
module l2_pf_cov_rolling_ctrl
  import l2_pf_cov_pkg::*;
#(
  parameter int unsigned WINDOW = 1000,
  parameter int          CNT_W  = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [2:0]       inc_y,
  input  logic [2:0]       inc_x,
  output logic             out_en,
  output logic [CNT_W-1:0] out_yAxisPt,
  output logic [CNT_W-1:0] out_xAxisPt,
  output logic [CNT_W-1:0] out_stamp
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  pf_cov_state_e    state_q, state_d;
  logic [CNT_W-1:0] stamp_q;
  logic [CNT_W-1:0] x_win_q, x_win_d;
  logic [CNT_W-1:0] y_win_q, y_win_d;
  logic [CNT_W-1:0] x_tot_q, x_tot_d;
  logic             out_en_q, out_en_d;
  logic [CNT_W-1:0] rec_y_q, rec_y_d;
  logic [CNT_W-1:0] rec_x_q, rec_x_d;
  logic [CNT_W-1:0] rec_s_q, rec_s_d;

  // Window totals as they would stand after this cycle's increments.
  logic [CNT_W-1:0] x_sum, y_sum, x_tot_sum;
  logic             win_nz, sum_nz, hit;

  assign x_sum     = x_win_q + CNT_W'(inc_x);
  assign y_sum     = y_win_q + CNT_W'(inc_y);
  assign x_tot_sum = x_tot_q + CNT_W'(inc_x);
  assign win_nz    = (x_win_q != '0) || (y_win_q != '0);
  assign sum_nz    = (x_sum != '0) || (y_sum != '0);
  assign hit       = (x_sum >= WIN);

  // Next-state, window update and record capture for the sampling FSM.
  always_comb begin
    state_d  = state_q;
    x_win_d  = x_win_q;
    y_win_d  = y_win_q;
    x_tot_d  = x_tot_q;
    out_en_d = 1'b0;
    rec_y_d  = rec_y_q;
    rec_x_d  = rec_x_q;
    rec_s_d  = rec_s_q;
    case (state_q)
      ST_OFF, ST_ACCUM: begin
        if (!enable) begin
          // Falling enable drops this cycle's increments; a partial window is drained.
          if (state_q == ST_ACCUM) begin
            state_d = win_nz ? ST_DRAIN : ST_OFF;
          end
        end else begin
          state_d = ST_ACCUM;
          x_win_d = x_sum;
          y_win_d = y_sum;
          x_tot_d = x_tot_sum;
          if (flush && (state_q == ST_ACCUM) && sum_nz) begin
            // Flush wins over a coincident crossing: one record, no remainder kept.
            out_en_d = 1'b1;
            x_win_d  = '0;
            y_win_d  = '0;
          end else if (hit) begin
            out_en_d = 1'b1;
            x_win_d  = x_sum - WIN;
            y_win_d  = '0;
          end
          if (out_en_d) begin
            rec_y_d = y_sum;
            rec_x_d = x_tot_sum;
            rec_s_d = stamp_q;
          end
        end
      end
      ST_DRAIN: begin
        out_en_d = 1'b1;
        rec_y_d  = y_win_q;
        rec_x_d  = x_tot_q;
        rec_s_d  = stamp_q;
        x_win_d  = '0;
        y_win_d  = '0;
        if (enable) begin
          state_d = ST_ACCUM;
          x_win_d = CNT_W'(inc_x);
          y_win_d = CNT_W'(inc_y);
          x_tot_d = x_tot_sum;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Free-running stamp, window counters and the registered output record.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stamp_q  <= '0;
      x_win_q  <= '0;
      y_win_q  <= '0;
      x_tot_q  <= '0;
      out_en_q <= 1'b0;
      rec_y_q  <= '0;
      rec_x_q  <= '0;
      rec_s_q  <= '0;
    end else begin
      stamp_q  <= stamp_q + 1'b1;
      x_win_q  <= x_win_d;
      y_win_q  <= y_win_d;
      x_tot_q  <= x_tot_d;
      out_en_q <= out_en_d;
      rec_y_q  <= rec_y_d;
      rec_x_q  <= rec_x_d;
      rec_s_q  <= rec_s_d;
    end
  end

  assign out_en      = out_en_q;
  assign out_yAxisPt = rec_y_q;
  assign out_xAxisPt = rec_x_q;
  assign out_stamp   = rec_s_q;

endmodule

// File: tb/tb_l2_pf_cov_rolling_ctrl.sv
// tb/tb_l2_pf_cov_rolling_ctrl.sv - randomized and directed bench for the coverage rolling controller
module tb_l2_pf_cov_rolling_ctrl;
  import l2_pf_cov_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  inc_y = '0;
  logic [2:0]  inc_x = '0;
  logic        out_en;
  logic [63:0] out_yAxisPt, out_xAxisPt, out_stamp;

  int errors = 0;
  int checks = 0;

  l2_pf_cov_rolling_ctrl #(.WINDOW(8), .CNT_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .inc_y       (inc_y),
    .inc_x       (inc_x),
    .out_en      (out_en),
    .out_yAxisPt (out_yAxisPt),
    .out_xAxisPt (out_xAxisPt),
    .out_stamp   (out_stamp)
  );

  always #5 clock = ~clock;

  // Reference model: sampling flag, pending drain, window/total counts, cycle number.
  bit          m_on, m_drain;
  logic [63:0] m_xw, m_yw, m_xt, m_stamp;
  bit          exp_en;
  pf_cov_rec_t exp_rec;

  task automatic model_reset();
    m_on = 0; m_drain = 0;
    m_xw = 0; m_yw = 0; m_xt = 0; m_stamp = 0;
    exp_en = 0; exp_rec = '0;
  endtask

  task automatic model_step(input bit en, input bit fl, input logic [2:0] iy, input logic [2:0] ix);
    bit emit;
    emit = 0;
    if (m_drain) begin
      emit = 1;
      exp_rec.yAxisPt = m_yw; exp_rec.xAxisPt = m_xt; exp_rec.stamp = m_stamp;
      m_xw = 0; m_yw = 0; m_drain = 0;
      m_on = en;
      if (en) begin m_xw = 64'(ix); m_yw = 64'(iy); m_xt = m_xt + 64'(ix); end
    end else if (!en) begin
      if (m_on && (m_xw != 0 || m_yw != 0)) m_drain = 1;
      m_on = 0;
    end else begin
      bit fl_ok;
      fl_ok = fl && m_on;
      m_on = 1;
      m_xw = m_xw + 64'(ix); m_yw = m_yw + 64'(iy); m_xt = m_xt + 64'(ix);
      if (fl_ok && (m_xw != 0 || m_yw != 0)) begin
        emit = 1;
        exp_rec.yAxisPt = m_yw; exp_rec.xAxisPt = m_xt; exp_rec.stamp = m_stamp;
        m_xw = 0; m_yw = 0;
      end else if (m_xw >= 8) begin
        emit = 1;
        exp_rec.yAxisPt = m_yw; exp_rec.xAxisPt = m_xt; exp_rec.stamp = m_stamp;
        m_xw = m_xw - 8; m_yw = 0;
      end
    end
    exp_en = emit;
    m_stamp = m_stamp + 1;
  endtask

  task automatic drive(input bit en, input bit fl, input logic [2:0] iy, input logic [2:0] ix);
    enable = en; flush = fl; inc_y = iy; inc_x = ix;
    model_step(en, fl, iy, ix);
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    enable = 0; flush = 0; inc_y = 0; inc_x = 0;
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b0, 192'd0}) begin
      errors++;
      $display("FAIL reset_state got en=%b y=%0d x=%0d s=%0d want all 0", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    apply_reset();
  endtask

  task automatic test_threshold();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'd1, 3'd3);
      checks++;
      if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {exp_en, exp_rec}) begin
        errors++;
        $display("FAIL threshold_model cyc=%0d got en=%b y=%0d x=%0d s=%0d want en=%b y=%0d x=%0d s=%0d", i,
                 out_en, out_yAxisPt, out_xAxisPt, out_stamp, exp_en, exp_rec.yAxisPt, exp_rec.xAxisPt, exp_rec.stamp);
      end
    end
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd3, 64'd9, 64'd2}) begin
      errors++;
      $display("FAIL threshold_record got en=%b y=%0d x=%0d s=%0d want en=1 y=3 x=9 s=2", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    drive(1, 0, 3'd0, 3'd7);
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd0, 64'd16, 64'd3}) begin
      errors++;
      $display("FAIL threshold_remainder got en=%b y=%0d x=%0d s=%0d want en=1 y=0 x=16 s=3", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'd0, 3'd2);
      checks++;
      if (out_en !== 1'b0) begin
        errors++;
        $display("FAIL flush_pre cyc=%0d got en=%b want 0", i, out_en);
      end
    end
    drive(1, 1, 3'd0, 3'd2);
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd0, 64'd8, 64'd3}) begin
      errors++;
      $display("FAIL flush_threshold got en=%b y=%0d x=%0d s=%0d want en=1 y=0 x=8 s=3", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    drive(1, 0, 3'd0, 3'd7);
    checks++;
    if ({out_en, out_xAxisPt} !== {1'b0, 64'd8}) begin
      errors++;
      $display("FAIL flush_no_remainder got en=%b x=%0d want en=0 x=8", out_en, out_xAxisPt);
    end
  endtask

  task automatic test_drain();
    apply_reset();
    drive(1, 0, 3'd1, 3'd2);
    drive(1, 0, 3'd1, 3'd2);
    drive(0, 0, 3'd1, 3'd2);
    checks++;
    if (out_en !== 1'b0) begin
      errors++;
      $display("FAIL drain_entry got en=%b want 0", out_en);
    end
    drive(0, 0, 3'd0, 3'd0);
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd2, 64'd4, 64'd3}) begin
      errors++;
      $display("FAIL drain_record got en=%b y=%0d x=%0d s=%0d want en=1 y=2 x=4 s=3", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    drive(0, 1, 3'd5, 3'd5);
    drive(1, 0, 3'd0, 3'd7);
    checks++;
    if ({out_en, out_xAxisPt} !== {1'b0, 64'd4}) begin
      errors++;
      $display("FAIL drain_then_off got en=%b x=%0d want en=0 x=4", out_en, out_xAxisPt);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 3'(i % 3), 3'd7);
      if (out_en === 1'b1) pulses++;
      checks++;
      if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {exp_en, exp_rec}) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got en=%b y=%0d x=%0d s=%0d want en=%b y=%0d x=%0d s=%0d", i,
                 out_en, out_yAxisPt, out_xAxisPt, out_stamp, exp_en, exp_rec.yAxisPt, exp_rec.xAxisPt, exp_rec.stamp);
      end
    end
    checks++;
    if ({pulses, out_xAxisPt} !== {32'd14, 64'd112}) begin
      errors++;
      $display("FAIL b2b_count got pulses=%0d x=%0d want pulses=14 x=112", pulses, out_xAxisPt);
    end
  endtask

  task automatic test_flush_empty();
    apply_reset();
    drive(0, 1, 3'd3, 3'd3);
    drive(0, 1, 3'd0, 3'd0);
    drive(1, 0, 3'd0, 3'd0);
    drive(1, 1, 3'd0, 3'd0);
    checks++;
    if (out_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got en=%b want 0", out_en);
    end
    drive(1, 1, 3'd0, 3'd0);
    checks++;
    if ({out_en, out_xAxisPt} !== {1'b0, 64'd0}) begin
      errors++;
      $display("FAIL flush_empty_again got en=%b x=%0d want en=0 x=0", out_en, out_xAxisPt);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 3'd1, 3'd3);
    #2;
    reset = 1;
    #1;
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b0, 192'd0}) begin
      errors++;
      $display("FAIL async_reset got en=%b y=%0d x=%0d s=%0d want all 0", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    @(posedge clock);
    #1;
    reset = 0;
    model_reset();
    checks++;
    if (out_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_norecord got en=%b want 0", out_en);
    end
    drive(1, 0, 3'd0, 3'd4);
    drive(1, 0, 3'd0, 3'd4);
    checks++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd0, 64'd8, 64'd1}) begin
      errors++;
      $display("FAIL async_reset_restart got en=%b y=%0d x=%0d s=%0d want en=1 y=0 x=8 s=1", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      checks++;
      if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {exp_en, exp_rec}) begin
        errors++;
        $display("FAIL random cyc=%0d got en=%b y=%0d x=%0d s=%0d want en=%b y=%0d x=%0d s=%0d", i,
                 out_en, out_yAxisPt, out_xAxisPt, out_stamp, exp_en, exp_rec.yAxisPt, exp_rec.xAxisPt, exp_rec.stamp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_threshold();
    test_flush();
    test_drain();
    test_back_to_back();
    test_flush_empty();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
